id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset; one clock; no other clock or reset.
REQ-003 SHALL have s_valid  input  1, s_ready  output  1: decode-side handshake; transfer when both are 1 on a clk edge.
REQ-004 SHALL have s_rs_data/s_rt_data/s_imm  input  32 each: register-file operands and sign-extended immediate.
REQ-005 SHALL have s_rs/s_rt/s_rd  input  5 each: source and destination register numbers.
REQ-006 SHALL have s_alu_src  input  1 (1 = immediate as in2), s_alu_control  input  4, s_reg_write  input  1.
REQ-007 SHALL have flush  input  1: discard all held and incoming entries.
REQ-008 SHALL have m_valid  output  1, m_ready  input  1: ALU-side handshake, same transfer rule.
REQ-009 SHALL have in1/in2  output  32, aluControl  output  4: drive the ALU ports directly.
REQ-010 SHALL have m_rd  output  5, m_reg_write  output  1: carried to EX/MEM.
REQ-011 SHALL have fwd_valid  input  1, fwd_rd  input  5, fwd_data  input  32: EX/MEM writeback bypass; present in both builds.

Function
REQ-012 SHALL hold up to two entries (main, skid); outputs SHALL come only from main; order SHALL be preserved.
REQ-013 Payload captured at acceptance: in1 = s_rs_data; in2 = s_alu_src ? s_imm : s_rt_data; remaining fields pass unchanged.
REQ-014 Latency SHALL be one cycle: an entry accepted at edge N into an empty block SHALL show m_valid=1 after edge N.
REQ-015 s_ready SHALL be a register output, 1 exactly when skid is empty; never combinationally dependent on m_ready.
REQ-016 Main empty or draining (m_ready=1) and s_valid=1: new entry (or skid entry, if skid occupied) SHALL load main; skid SHALL drain before new data.
REQ-017 Main full, m_ready=0, s_valid=1, s_ready=1: entry SHALL go to skid; s_ready SHALL fall next cycle.
REQ-018 Both full, m_ready=1: skid SHALL move to main, skid empties, s_ready rises next cycle.
REQ-019 Simultaneous accept and drain with skid empty SHALL replace main with new entry; m_valid stays 1 with no bubble.
REQ-020 m_valid SHALL hold stable with payload unchanged while m_ready=0.
REQ-021 flush=1 SHALL clear both entries at that edge; any same-edge s_valid entry SHALL be dropped; s_ready=1 after.
REQ-022 Payload registers SHALL retain last values when m_valid=0; consumers SHALL ignore them.

Reset
REQ-023 reset=1 at an edge SHALL clear m_valid=0, s_ready=1, both entries empty, in1=in2=0, aluControl=0, m_rd=0, m_reg_write=0.
REQ-024 reset SHALL take priority over flush and all handshakes, including mid-transfer; no entry survives.

Configuration
REQ-025 Macro ID_EX_FORWARDING_EN defined: at acceptance, if fwd_valid=1, fwd_rd!=0 and fwd_rd==s_rs, in1 SHALL take fwd_data; same for s_rt to in2 only when s_alu_src=0.
REQ-026 Macro ID_EX_FORWARDING_EN undefined: fwd_* inputs SHALL be ignored; capture per REQ-013 only.

Verification
REQ-027 Reset then s_rs_data=5, s_rt_data=7, s_alu_control=0010, s_alu_src=0, m_ready=1 -> next cycle m_valid=1, in1=5, in2=7, aluControl=0010.
REQ-028 m_ready=0, push A, B, C on consecutive cycles -> A in main, B in skid, s_ready=0, C not accepted; m_ready=1 -> A, B out in order, s_ready=1.
REQ-029 s_alu_src=1, s_imm=32'hFFFFFFFC, s_rt_data=9 -> in2=32'hFFFFFFFC.
REQ-030 Both entries full, flush=1 with s_valid=1 -> next cycle m_valid=0, s_ready=1, no entry emitted.
REQ-031 FORWARDING_EN: s_rs=3, fwd_valid=1, fwd_rd=3, fwd_data=42, s_rs_data=1 -> in1=42; fwd_rd=0 -> in1=1; macro off -> in1=1.
REQ-032 reset asserted with both entries full and m_ready=1 -> next cycle all outputs per REQ-023.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: a two-entry elastic stage (main + skid) between
// the decode and ALU handshakes. It captures the ALU operands when an entry
// is accepted.
// Optional build macro: ID_EX_FORWARDING_EN. When it is defined, the
// EX/MEM writeback bypass (fwd_*) is applied at capture. When it is not
// defined, the fwd_* inputs are ignored.
module id_ex_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_rs_data,
  input  logic [31:0] s_rt_data,
  input  logic [31:0] s_imm,
  input  logic [4:0]  s_rs,
  input  logic [4:0]  s_rt,
  input  logic [4:0]  s_rd,
  input  logic        s_alu_src,
  input  logic [3:0]  s_alu_control,
  input  logic        s_reg_write,
  input  logic        flush,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [3:0]  aluControl,
  output logic [4:0]  m_rd,
  output logic        m_reg_write,
  input  logic        fwd_valid,
  input  logic [4:0]  fwd_rd,
  input  logic [31:0] fwd_data
);

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   s_ready_q, s_ready_d;
  logic   accept;

  // Build the entry that would be captured from the decode side this cycle
  always_comb begin
    new_entry.in1 = s_rs_data;
    new_entry.in2 = s_alu_src ? s_imm : s_rt_data;
    new_entry.alu = s_alu_control;
    new_entry.rd  = s_rd;
    new_entry.rw  = s_reg_write;
`ifdef ID_EX_FORWARDING_EN
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == s_rs))
      new_entry.in1 = fwd_data;
    if (!s_alu_src && fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == s_rt))
      new_entry.in2 = fwd_data;
`endif
  end

`ifndef ID_EX_FORWARDING_EN
  // The bypass inputs stay on the port list in both builds; fold them into
  // a single dead net so that they are visibly consumed.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
`endif

  assign accept = s_valid && s_ready_q;

  // Next-state for the two entries; the skid always drains ahead of new data
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || m_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
    s_ready_d = !skid_valid_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = main_valid_q;
  assign in1         = main_q.in1;
  assign in2         = main_q.in2;
  assign aluControl  = main_q.alu;
  assign m_rd        = main_q.rd;
  assign m_reg_write = main_q.rw;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg. It uses a directed vector table,
// a few hand-written sequences, and randomized traffic checked against an
// occupancy/queue model of the stage.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, s_alu_src, s_reg_write, flush;
  logic        m_valid, m_ready, m_reg_write, fwd_valid;
  logic [31:0] s_rs_data, s_rt_data, s_imm, in1, in2, fwd_data;
  logic [4:0]  s_rs, s_rt, s_rd, m_rd, fwd_rd;
  logic [3:0]  s_alu_control, aluControl;

  int n_cmp = 0;
  int n_fail = 0;

  id_ex_reg dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_rs_data(s_rs_data), .s_rt_data(s_rt_data), .s_imm(s_imm),
    .s_rs(s_rs), .s_rt(s_rt), .s_rd(s_rd), .s_alu_src(s_alu_src),
    .s_alu_control(s_alu_control), .s_reg_write(s_reg_write), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .in1(in1), .in2(in2),
    .aluControl(aluControl), .m_rd(m_rd), .m_reg_write(m_reg_write),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
  } pkt_t;

  pkt_t q[$];
  pkt_t held;

  function automatic pkt_t capture();
    pkt_t p;
    p.in1 = s_rs_data;
    p.in2 = s_alu_src ? s_imm : s_rt_data;
    p.alu = s_alu_control;
    p.rd  = s_rd;
    p.rw  = s_reg_write;
`ifdef ID_EX_FORWARDING_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == s_rs) p.in1 = fwd_data;
    if (!s_alu_src && fwd_valid && fwd_rd != 0 && fwd_rd == s_rt) p.in2 = fwd_data;
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare every output against it.
  task automatic step();
    bit can_push;
    @(posedge clk);
    if (reset) begin
      q.delete();
      held = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      can_push = (q.size() < 2);
      if (q.size() > 0 && m_ready) void'(q.pop_front());
      if (s_valid && can_push) q.push_back(capture());
    end
    if (q.size() > 0) held = q[0];
    #1;
    check("m_valid", 74'(m_valid), 74'(q.size() > 0));
    check("s_ready", 74'(s_ready), 74'(q.size() < 2));
    check("payload", {in1, in2, aluControl, m_rd, m_reg_write}, held);
  endtask

  task automatic idle_inputs();
    reset = 0; s_valid = 0; flush = 0; m_ready = 0;
    s_rs_data = 0; s_rt_data = 0; s_imm = 0; s_rs = 0; s_rt = 0; s_rd = 0;
    s_alu_src = 0; s_alu_control = 0; s_reg_write = 0;
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
  endtask

  typedef struct {
    logic        sv;
    logic [31:0] rs_d, rt_d, imm;
    logic        src;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr, fl;
    logic        e_mv, e_sr, chk;
    logic [31:0] e_in1, e_in2;
    logic [3:0]  e_alu;
    logic [4:0]  e_rd;
    logic        e_rw;
  } vec_t;

  vec_t vt[12];
  logic [31:0] exp_in1;

  initial begin
    //        sv rs_d      rt_d      imm           src alu rd rw mr fl  mv sr chk in1       in2           alu rd rw
    vt[0]  = '{1, 32'd5,    32'd7,    32'd0,        0, 2, 1, 1, 1, 0,  1, 1, 1, 32'd5,    32'd7,        2, 1, 1};
    vt[1]  = '{1, 32'd11,   32'd9,    32'hFFFFFFFC, 1, 3, 2, 0, 1, 0,  1, 1, 1, 32'd11,   32'hFFFFFFFC, 3, 2, 0};
    vt[2]  = '{0, 32'd0,    32'd0,    32'd0,        0, 0, 0, 0, 1, 0,  0, 1, 0, 32'd0,    32'd0,        0, 0, 0};
    vt[3]  = '{1, 32'h100,  32'h101,  32'd0,        0, 4, 3, 1, 0, 0,  1, 1, 1, 32'h100,  32'h101,      4, 3, 1};
    vt[4]  = '{1, 32'h200,  32'h201,  32'd0,        0, 5, 4, 0, 0, 0,  1, 0, 1, 32'h100,  32'h101,      4, 3, 1};
    vt[5]  = '{1, 32'h300,  32'h301,  32'd0,        0, 6, 5, 1, 0, 0,  1, 0, 1, 32'h100,  32'h101,      4, 3, 1};
    vt[6]  = '{1, 32'h300,  32'h301,  32'd0,        0, 6, 5, 1, 1, 0,  1, 1, 1, 32'h200,  32'h201,      5, 4, 0};
    vt[7]  = '{0, 32'd0,    32'd0,    32'd0,        0, 0, 0, 0, 1, 0,  0, 1, 0, 32'd0,    32'd0,        0, 0, 0};
    vt[8]  = '{1, 32'h400,  32'h401,  32'd0,        0, 7, 6, 1, 0, 0,  1, 1, 1, 32'h400,  32'h401,      7, 6, 1};
    vt[9]  = '{1, 32'h500,  32'h501,  32'd0,        0, 8, 7, 0, 0, 0,  1, 0, 1, 32'h400,  32'h401,      7, 6, 1};
    vt[10] = '{1, 32'h600,  32'h601,  32'd0,        0, 9, 8, 1, 0, 1,  0, 1, 0, 32'd0,    32'd0,        0, 0, 0};
    vt[11] = '{0, 32'd0,    32'd0,    32'd0,        0, 0, 0, 0, 1, 0,  0, 1, 0, 32'd0,    32'd0,        0, 0, 0};

    held = '0;
    idle_inputs();
    reset = 1;
    step();
    step();
    check("reset_m_valid", 74'(m_valid), 74'(0));
    check("reset_s_ready", 74'(s_ready), 74'(1));
    check("reset_outs", {in1, in2, aluControl, m_rd, m_reg_write}, 74'(0));
    reset = 0;

    // Directed vector table: latency, immediate select, skid order, and flush
    for (int i = 0; i < 12; i++) begin
      s_valid = vt[i].sv; s_rs_data = vt[i].rs_d; s_rt_data = vt[i].rt_d;
      s_imm = vt[i].imm; s_alu_src = vt[i].src; s_alu_control = vt[i].alu;
      s_rd = vt[i].rd; s_reg_write = vt[i].rw; m_ready = vt[i].mr; flush = vt[i].fl;
      step();
      check($sformatf("vec%0d_m_valid", i), 74'(m_valid), 74'(vt[i].e_mv));
      check($sformatf("vec%0d_s_ready", i), 74'(s_ready), 74'(vt[i].e_sr));
      if (vt[i].chk)
        check($sformatf("vec%0d_payload", i), {in1, in2, aluControl, m_rd, m_reg_write},
              {vt[i].e_in1, vt[i].e_in2, vt[i].e_alu, vt[i].e_rd, vt[i].e_rw});
    end
    idle_inputs();

    // Forwarding: match on s_rs, then fwd_rd = 0 must never forward
    s_valid = 1; m_ready = 1; s_rs = 3; s_rs_data = 1; s_rt = 4; s_rt_data = 2;
    fwd_valid = 1; fwd_rd = 3; fwd_data = 42;
    step();
`ifdef ID_EX_FORWARDING_EN
    exp_in1 = 42;
`else
    exp_in1 = 1;
`endif
    check("fwd_in1", 74'(in1), 74'(exp_in1));
    check("fwd_in2_no_match", 74'(in2), 74'(2));
    fwd_rd = 0; s_rs = 0;
    step();
    check("fwd_rd0_in1", 74'(in1), 74'(1));
    idle_inputs();
    step();

    // Reset with both entries full and m_ready=1, plus flush and s_valid
    s_valid = 1; s_rs_data = 32'hA; s_rd = 9; s_reg_write = 1; s_alu_control = 4'hF;
    step();
    s_rs_data = 32'hB;
    step();
    check("full_s_ready", 74'(s_ready), 74'(0));
    reset = 1; m_ready = 1; flush = 1;
    step();
    check("rst_full_m_valid", 74'(m_valid), 74'(0));
    check("rst_full_s_ready", 74'(s_ready), 74'(1));
    check("rst_full_outs", {in1, in2, aluControl, m_rd, m_reg_write}, 74'(0));
    idle_inputs();
    m_ready = 1;
    step();
    check("rst_no_survivor", 74'(m_valid), 74'(0));

    // Randomized traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      s_valid = $urandom_range(0, 1);
      m_ready = ($urandom_range(0, 9) < 6);
      s_rs_data = $urandom; s_rt_data = $urandom; s_imm = $urandom;
      s_rs = 5'($urandom_range(0, 3)); s_rt = 5'($urandom_range(0, 3));
      s_rd = 5'($urandom); s_alu_src = $urandom_range(0, 1);
      s_alu_control = 4'($urandom); s_reg_write = $urandom_range(0, 1);
      fwd_valid = $urandom_range(0, 1); fwd_rd = 5'($urandom_range(0, 3));
      fwd_data = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
